spla_res39_onset_enum: RTL

//  Sequential on-set enumerator, the generator side of the 13-input spla restriction-39 function
//  y0 = ~x0&~x1&~x2&~x3&x4&x5&x6&~x7&x8&((x9&x10)|(x11&x12)).

---
 rtl/spla_res39_onset_enum.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spla_res39_onset_enum.sv
`default_nettype none
// ============================================================================
// Module      : spla_res39_onset_enum
// Description : Sequential on-set enumerator for the 13-input spla
//               restriction-39 function
//                 y0 = ~x0&~x1&~x2&~x3&x4&x5&x6&~x7&x8&((x9&x10)|(x11&x12))
//               Scans input indices RANGE_LO..RANGE_HI in ascending order,
//               one index per cycle, and streams every index with y0=1 over
//               a valid/ready handshake. Also counts the accepted vectors.
//               Vector bit i carries xi.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               start      pulse, begins a scan from IDLE or DONE
//               abort      forces a return to IDLE (highest priority)
//               out_valid  out_vec holds an on-set vector
//               out_ready  consumer accepts out_vec on out_valid&out_ready
//               out_vec    on-set vector, bit i = xi
//               hit_count  vectors accepted since the last start (saturating)
//               busy       scan in progress (SCAN or HOLD)
//               done       level, high in DONE until the next start/abort
// Revision    : 1.0 - initial release
// ============================================================================
module spla_res39_onset_enum #(
  parameter logic [12:0] RANGE_LO = 13'h0000,
  parameter logic [12:0] RANGE_HI = 13'h1FFF,
  parameter int          COUNT_W  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [12:0]        out_vec,
  output logic [COUNT_W-1:0] hit_count,
  output logic               busy,
  output logic               done
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [COUNT_W-1:0] c_HIT_MAX = '1;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [12:0]        idx_q;
  logic [12:0]        out_vec_q;
  logic               out_valid_q;
  logic               last_q;
  logic [COUNT_W-1:0] hit_count_q;

  logic               w_hit;
  logic               w_at_hi;
  logic               w_xfer;

  // --------------------------------------------------------------------------
  // Function under enumeration, evaluated on the current scan index
  // --------------------------------------------------------------------------
  assign w_hit = ~idx_q[0] & ~idx_q[1] & ~idx_q[2] & ~idx_q[3] &
                  idx_q[4] &  idx_q[5] &  idx_q[6] & ~idx_q[7] &
                  idx_q[8] & ((idx_q[9] & idx_q[10]) | (idx_q[11] & idx_q[12]));

  // The index never steps past RANGE_HI, so RANGE_HI = 13'h1FFF cannot wrap
  // back to zero; termination is decided by this compare and the last flag.
  assign w_at_hi = (idx_q == RANGE_HI);

  // Handshake uses the registered valid only, so out_ready never reaches
  // out_valid combinationally.
  assign w_xfer  = out_valid_q & out_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; abort overrides start and the handshake
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE, c_DONE: begin
          if (start) begin
            state_d = c_SCAN;
          end
        end
        c_SCAN: begin
          if (w_hit) begin
            state_d = c_HOLD;
          end else if (w_at_hi) begin
            state_d = c_DONE;
          end
        end
        c_HOLD: begin
          if (w_xfer) begin
            state_d = last_q ? c_DONE : c_SCAN;
          end
        end
        default: state_d = c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers: scan index, presented vector, last flag, hit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= RANGE_LO;
      out_vec_q   <= 13'h0000;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      hit_count_q <= '0;
    end else if (abort) begin
      // idx and hit_count are kept; a vector in flight is dropped uncounted.
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        c_IDLE, c_DONE: begin
          if (start) begin
            idx_q       <= RANGE_LO;
            hit_count_q <= '0;
            last_q      <= 1'b0;
          end
        end
        c_SCAN: begin
          if (w_hit) begin
            out_vec_q   <= idx_q;
            out_valid_q <= 1'b1;
            last_q      <= w_at_hi;
          end
          if (!w_at_hi) begin
            idx_q <= idx_q + 13'd1;
          end
        end
        c_HOLD: begin
          if (w_xfer) begin
            out_valid_q <= 1'b0;
            if (hit_count_q != c_HIT_MAX) begin
              hit_count_q <= hit_count_q + 1'b1;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == c_SCAN) || (state_q == c_HOLD);
    done = (state_q == c_DONE);
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign hit_count = hit_count_q;

endmodule
`default_nettype wire
